// File: rtl/tcam_bank_search_pkg.sv
// ============================================================================
// Package : tcam_pkg
// Brief   : Shared types, sizes and the lowest-index priority encoder for the
//           cascaded-slice ternary CAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tcam_pkg;

  localparam int SLICE_W = 7;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_WRITE  = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Lowest set bit wins; an all-zero vector encodes to 0.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [ENTRIES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcam_bank_search_if.sv
// ============================================================================
// Interface : tcam_bank_search_if
// Brief     : Request/result bundle between the RoCC front end and the TCAM.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface tcam_bank_search_if #(
  parameter int KEY_W = 28,
  parameter int SEL_W = 2
);
  logic               in_valid;
  logic               out_ready;
  logic [1:0]         in_op;
  logic [KEY_W-1:0]   in_key;
  logic [SEL_W+7:0]   in_addr;
  logic [3:0]         in_wmask;
  logic [31:0]        in_wdata;
  logic               out_valid;
  logic               out_hit;
  logic [5:0]         out_idx;
  logic [63:0]        out_match;

  modport master (
    output in_valid, in_op, in_key, in_addr, in_wmask, in_wdata,
    input  out_ready, out_valid, out_hit, out_idx, out_match
  );

  modport slave (
    input  in_valid, in_op, in_key, in_addr, in_wmask, in_wdata,
    output out_ready, out_valid, out_hit, out_idx, out_match
  );
endinterface

`default_nettype wire

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
// ============================================================================
// Module : sky130_sram_1kbyte_1rw1r_32x256_8
// Brief  : Behavioural stand-in for the 32x256 1RW+1R SRAM macro. Port 0 is
//          read/write with byte mask, port 1 is read-only; reads return data
//          on the clock edge after the address is presented.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sky130_sram_1kbyte_1rw1r_32x256_8 (
  input  wire         clk0,
  input  wire         csb0,
  input  wire         web0,
  input  wire  [3:0]  wmask0,
  input  wire  [7:0]  addr0,
  input  wire  [31:0] din0,
  output logic [31:0] dout0,
  input  wire         clk1,
  input  wire         csb1,
  input  wire  [7:0]  addr1,
  output logic [31:0] dout1
);
  logic [31:0] r_mem [256];

  // Port 0: byte-masked write or synchronous read.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) r_mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
      end else begin
        dout0 <= r_mem[addr0];
      end
    end
  end

  // Port 1: synchronous read only.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= r_mem[addr1];
  end
endmodule

`default_nettype wire

// File: rtl/tcam_bank_search_slice.sv
// ============================================================================
// Module : tcam_slice
// Brief  : One 7-bit key slice: an SRAM macro whose rows are key values and
//          whose bits are entries. Muxes clear / write / search onto the ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcam_slice
  import tcam_pkg::*;
(
  input  wire                 i_clk,
  input  wire                 i_clr,
  input  wire  [7:0]          i_clr_row,
  input  wire                 i_wr,
  input  wire  [7:0]          i_row,
  input  wire  [3:0]          i_wmask,
  input  wire  [31:0]         i_wdata,
  input  wire                 i_srch,
  input  wire  [SLICE_W-1:0]  i_key,
  output logic [ENTRIES-1:0]  o_vec
);
  logic        w_csb0;
  logic        w_web0;
  logic [3:0]  w_wmask0;
  logic [7:0]  w_addr0;
  logic [31:0] w_din0;
  logic [31:0] w_dout0;
  logic        w_csb1;
  logic [7:0]  w_addr1;
  logic [31:0] w_dout1;

  // Port select: clearing owns port 0 outright; a search reads both halves.
  always_comb begin
    w_csb0   = 1'b1;
    w_web0   = 1'b1;
    w_wmask0 = 4'h0;
    w_addr0  = 8'h00;
    w_din0   = 32'h0;
    w_csb1   = 1'b1;
    w_addr1  = 8'h00;
    if (i_clr) begin
      w_csb0   = 1'b0;
      w_web0   = 1'b0;
      w_wmask0 = 4'hF;
      w_addr0  = i_clr_row;
    end else if (i_wr) begin
      w_csb0   = 1'b0;
      w_web0   = 1'b0;
      w_wmask0 = i_wmask;
      w_addr0  = i_row;
      w_din0   = i_wdata;
    end else if (i_srch) begin
      w_csb0   = 1'b0;
      w_addr0  = {1'b0, i_key};
      w_csb1   = 1'b0;
      w_addr1  = {1'b1, i_key};
    end
  end

  sky130_sram_1kbyte_1rw1r_32x256_8 u_sram (
    .clk0   (i_clk),
    .csb0   (w_csb0),
    .web0   (w_web0),
    .wmask0 (w_wmask0),
    .addr0  (w_addr0),
    .din0   (w_din0),
    .dout0  (w_dout0),
    .clk1   (i_clk),
    .csb1   (w_csb1),
    .addr1  (w_addr1),
    .dout1  (w_dout1)
  );

  // Entries 32..63 live in the upper half of the macro (row bit 7 set).
  assign o_vec = {w_dout1, w_dout0};
endmodule

`default_nettype wire

// File: rtl/tcam_bank_search.sv
// ============================================================================
// Module : tcam_bank_search
// Brief  : N_SLICES cascaded 7-bit TCAM slices, 64 entries, with a 3-cycle
//          search pipeline (read, AND-reduce, priority encode) and a clear
//          sequencer that zeroes every row after reset or on request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tcam_bank_search
  import tcam_pkg::*;
#(
  parameter int N_SLICES = 4
) (
  input  wire                in_clk,
  input  wire                in_rst,
  tcam_bank_search_if.slave  bus
);
  localparam int SEL_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [8:0]         r_clr_cnt;
  logic [8:0]         w_cnt_nxt;
  logic               w_accept;
  logic               w_srch;
  logic               w_wr;
  logic               w_clr_req;
  logic               w_clearing;
  logic [SEL_W-1:0]   w_sel;
  logic [ENTRIES-1:0] w_vec [N_SLICES];
  logic [ENTRIES-1:0] w_and;
  logic               r_s1_valid;
  logic               r_s2_valid;
  logic [ENTRIES-1:0] r_m;
  logic               r_out_valid;
  logic               r_out_hit;
  logic [IDX_W-1:0]   r_out_idx;
  logic [ENTRIES-1:0] r_out_match;

  assign w_clearing    = (r_state == ST_CLEAR);
  assign bus.out_ready = (r_state == ST_IDLE);
  assign w_accept      = bus.in_valid & bus.out_ready;
  assign w_srch        = w_accept && (bus.in_op == OP_SEARCH);
  assign w_wr          = w_accept && (bus.in_op == OP_WRITE);
  assign w_clr_req     = w_accept && (bus.in_op == OP_CLEAR);
  // Out-of-range slice numbers wrap rather than being dropped.
  assign w_sel = SEL_W'(32'(bus.in_addr[SEL_W+7:8]) % 32'(N_SLICES));

  // State and clear-row counter; reset lands in CLEAR so the array starts zeroed.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= 9'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_cnt_nxt;
    end
  end

  // Next state: CLEAR walks rows 0..255 then returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clr_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 9'd0;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == 9'd255) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 9'd0;
        end else begin
          w_cnt_nxt   = r_clr_cnt + 9'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar s = 0; s < N_SLICES; s++) begin : g_slice
    tcam_slice u_slice (
      .i_clk     (in_clk),
      .i_clr     (w_clearing),
      .i_clr_row (r_clr_cnt[7:0]),
      .i_wr      (w_wr && (w_sel == SEL_W'(s))),
      .i_row     (bus.in_addr[7:0]),
      .i_wmask   (bus.in_wmask),
      .i_wdata   (bus.in_wdata),
      .i_srch    (w_srch),
      .i_key     (bus.in_key[s*SLICE_W +: SLICE_W]),
      .o_vec     (w_vec[s])
    );
  end

  // An entry matches only if every slice matched its part of the key.
  always_comb begin
    w_and = '1;
    for (int s = 0; s < N_SLICES; s++) begin
      w_and = w_and & w_vec[s];
    end
  end

  // Search pipeline: stage 1 registers the AND vector, stage 2 the result.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_m         <= '0;
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_out_match <= '0;
    end else begin
      r_s1_valid  <= w_srch;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      if (r_s1_valid) r_m <= w_and;
      if (r_s2_valid) begin
        r_out_match <= r_m;
        r_out_hit   <= |r_m;
        r_out_idx   <= prio_enc(r_m);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_hit   = r_out_hit;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_match = r_out_match;
endmodule

`default_nettype wire
